tdes_key_sched: RTL and testbench
=================================

TDES_KEY_SCHED -- requirements
Module: tdes_key_sched

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port key_load  input  1  start pulse; sample keys and begin schedule.
REQ-004 SHALL have port keys  input  192  session key bundle; K1=[63:0], K2=[127:64], K3=[191:128], DES bit 1 = MSB of each.
REQ-005 SHALL have port decrypt  input  1  read-order select (see Configuration).
REQ-006 SHALL have port rd_idx  input  6  subkey read index, 0..47.
REQ-007 SHALL have port subkey  output  48  combinational subkey read data.
REQ-008 SHALL have port busy  output  1  high while generating.
REQ-009 SHALL have port sched_done  output  1  high while a complete schedule is held.

Function
REQ-010 SHALL implement states IDLE, GEN, DONE.
REQ-011 SHALL, on key_load=1 in any state, register keys, clear count to 0, clear sched_done, and enter GEN next cycle.
REQ-012 SHALL, in GEN, write one subkey per cycle to storage[count] and increment count; storage 0-15 = K1 rounds 1-16, 16-31 = K2, 32-47 = K3.
REQ-013 SHALL derive each subkey per FIPS 46-3: PC-1 to C/D (28 bits each), left-rotate by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, then PC-2; C/D reload from PC-1 of next key at count 16 and 32.
REQ-014 SHALL leave GEN for DONE after the write at count 47; sched_done rises exactly 48 cycles after the key_load sampling edge.
REQ-015 SHALL hold busy=1 exactly in GEN and sched_done=1 exactly in DONE.
REQ-016 SHALL treat key_load during GEN as restart (abort, new keys, count=0); partial storage is overwritten.
REQ-017 SHALL map reads (encrypt order, EDE): rd_idx=16s+r -> s=0: storage[r]; s=1: storage[31-r]; s=2: storage[32+r].
REQ-018 SHALL drive subkey=0 for rd_idx 48..63.
REQ-019 SHALL allow reads in any state; reads during GEN return current storage content.

Reset
REQ-020 SHALL on n_rst=0 force IDLE, count=0, busy=0, sched_done=0, all storage and key registers to 0.
REQ-021 SHALL, on reset asserted mid-GEN, discard schedule; no output glitch to sched_done=1.

Configuration
REQ-022 SHALL, with TDES_KEY_DECRYPT_EN defined and decrypt=1, map reads (decrypt order, DED): s=0: storage[47-r]; s=1: storage[16+r]; s=2: storage[15-r].
REQ-023 SHALL, without TDES_KEY_DECRYPT_EN, ignore decrypt and always use REQ-017 mapping.

Structure
REQ-024 SHALL place state enum, PC-1/PC-2 tables, rotation schedule and constant 48 (TDES_NSUBKEYS) in package tdes_pkg.
REQ-025 SHALL use one sub-module des_key_round: combinational C/D rotate-by-1/2 plus PC-2.

Verification
REQ-026 keys = {3{64'h133457799BBCDFF1}}, key_load pulse -> sched_done high 48 cycles later; rd_idx 0 = 48'h1B02EFFC7072, rd_idx 15 = 48'hCB3D8B0E17F5.
REQ-027 same schedule, rd_idx 16 -> 48'hCB3D8B0E17F5, rd_idx 32 -> 48'h1B02EFFC7072, rd_idx 50 -> 0.
REQ-028 TDES_KEY_DECRYPT_EN, decrypt=1, same keys -> rd_idx 0 = 48'hCB3D8B0E17F5, rd_idx 16 = 48'h1B02EFFC7072.
REQ-029 key_load at count 20 with new keys -> busy stays high, sched_done 48 cycles after second pulse, entries match new-key model.
REQ-030 n_rst low at count 30 -> IDLE, busy=0, sched_done=0, all rd_idx read 0.
REQ-031 random keys x100 vs FIPS 46-3 reference model -> all 48 subkeys match.

Source files
------------

// File: rtl/tdes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tdes_pkg
// Purpose : Shared definitions for the Triple-DES key scheduler. Holds the
//           scheduler state encoding, the FIPS 46-3 PC-1/PC-2 permutation
//           tables, the per-round rotation schedule and the permutation helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package tdes_pkg;

  localparam int TDES_NSUBKEYS = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // FIPS 46-3 numbering: entry n names key bit n, bit 1 being the MSB.
  localparam logic [5:0] PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Entry n names bit n of the 56-bit C||D word, bit 1 being the MSB of C.
  localparam logic [5:0] PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied to C and D before each of rounds 1..16.
  localparam logic [1:0] ROT_TAB [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // PC-1: 64-bit key -> 56-bit C||D (C in [55:28]).
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (logic [5:0] i = 6'd0; i < 6'd56; i++) begin
      cd[6'd55 - i] = key[6'd63 - (PC1_TAB[i] - 6'd1)];
    end
    return cd;
  endfunction

  // PC-2: 56-bit C||D -> 48-bit round subkey.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] sk;
    sk = '0;
    for (logic [5:0] j = 6'd0; j < 6'd48; j++) begin
      sk[6'd47 - j] = cd[6'd56 - PC2_TAB[j]];
    end
    return sk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_round.sv
`default_nettype none
// ============================================================================
// Module  : des_key_round
// Purpose : One DES key-schedule step: rotates C and D left by 1 or 2 and
//           applies PC-2 to the rotated halves. Purely combinational.
// Ports   : c_in, d_in   28-bit halves before rotation
//           rot2         1 = rotate by two, 0 = rotate by one
//           c_out, d_out rotated halves (carried to the next round)
//           subkey       48-bit round subkey
// Rev     : 1.0  initial release
// ============================================================================
module des_key_round
  import tdes_pkg::*;
(
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  input  logic        rot2,
  output logic [27:0] c_out,
  output logic [27:0] d_out,
  output logic [47:0] subkey
);

  assign c_out  = rot2 ? {c_in[25:0], c_in[27:26]} : {c_in[26:0], c_in[27]};
  assign d_out  = rot2 ? {d_in[25:0], d_in[27:26]} : {d_in[26:0], d_in[27]};
  assign subkey = pc2({c_out, d_out});

endmodule
`default_nettype wire

// File: rtl/tdes_key_sched.sv
`default_nettype none
// ============================================================================
// Module  : tdes_key_sched
// Purpose : Triple-DES key scheduler. On key_load it captures K1/K2/K3 and
//           generates the 48 round subkeys, one per cycle, into storage
//           (0-15 K1, 16-31 K2, 32-47 K3). Reads are remapped to EDE
//           encrypt order, or DED decrypt order when TDES_KEY_DECRYPT_EN is
//           defined and decrypt=1.
// Ports   : clk, n_rst (async, active-low)
//           key_load    start / restart pulse
//           keys        {K3, K2, K1}, DES bit 1 = MSB of each 64-bit key
//           decrypt     read-order select (used only with TDES_KEY_DECRYPT_EN)
//           rd_idx      read index 0..47 (48..63 read as zero)
//           subkey      combinational read data
//           busy        high while generating
//           sched_done  high while a complete schedule is held
// Macro   : TDES_KEY_DECRYPT_EN enables the decrypt read ordering.
// Rev     : 1.0  initial release
// ============================================================================
module tdes_key_sched
  import tdes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [191:0] keys,
  input  logic         decrypt,
  input  logic [5:0]   rd_idx,
  output logic [47:0]  subkey,
  output logic         busy,
  output logic         sched_done
);

  state_t       state;
  state_t       state_nxt;
  logic [191:0] key_reg;
  logic [5:0]   count;
  logic [27:0]  c_reg;
  logic [27:0]  d_reg;
  logic [47:0]  storage [TDES_NSUBKEYS];
  logic         wr_en;
  logic         last_wr;

  logic [63:0]  seg_key;
  logic [55:0]  seg_cd;
  logic [27:0]  c_src;
  logic [27:0]  d_src;
  logic [27:0]  c_nxt;
  logic [27:0]  d_nxt;
  logic [47:0]  round_key;

  logic [3:0]   rd_r;
  logic [5:0]   rd_addr;
  logic         rd_valid;

  assign last_wr = (count == 6'(TDES_NSUBKEYS - 1));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    sched_done = 1'b0;
    wr_en      = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_GEN: begin
        busy  = 1'b1;
        wr_en = !key_load;
        if (last_wr) state_nxt = ST_DONE;
      end
      ST_DONE: sched_done = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
    // A load always (re)starts generation, whatever the current state.
    if (key_load) state_nxt = ST_GEN;
  end

  // --------------------------------------------------------------------------
  // Subkey generation. The first round of each key segment starts from PC-1
  // of that key; all other rounds continue from the carried C/D halves.
  // --------------------------------------------------------------------------
  always_comb begin
    case (count[5:4])
      2'd1:    seg_key = key_reg[127:64];
      2'd2:    seg_key = key_reg[191:128];
      default: seg_key = key_reg[63:0];
    endcase
  end

  assign seg_cd = pc1(seg_key);
  assign c_src  = (count[3:0] == 4'd0) ? seg_cd[55:28] : c_reg;
  assign d_src  = (count[3:0] == 4'd0) ? seg_cd[27:0]  : d_reg;

  des_key_round u_round (
    .c_in   (c_src),
    .d_in   (d_src),
    .rot2   (ROT_TAB[count[3:0]] == 2'd2),
    .c_out  (c_nxt),
    .d_out  (d_nxt),
    .subkey (round_key)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_reg <= '0;
      count   <= '0;
      c_reg   <= '0;
      d_reg   <= '0;
      storage <= '{default: '0};
    end else if (key_load) begin
      key_reg <= keys;
      count   <= '0;
    end else if (wr_en) begin
      storage[count] <= round_key;
      c_reg          <= c_nxt;
      d_reg          <= d_nxt;
      count          <= last_wr ? 6'd0 : count + 6'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Read remapping: rd_idx = 16*s + r selects stage s, round r of the
  // three-pass cipher; reverse-order stages walk their segment backwards.
  // --------------------------------------------------------------------------
  assign rd_r = rd_idx[3:0];

  always_comb begin
    rd_addr  = 6'd0;
    rd_valid = 1'b1;
`ifdef TDES_KEY_DECRYPT_EN
    if (decrypt) begin
      case (rd_idx[5:4])
        2'd0:    rd_addr = 6'd47 - {2'b00, rd_r};
        2'd1:    rd_addr = 6'd16 + {2'b00, rd_r};
        2'd2:    rd_addr = 6'd15 - {2'b00, rd_r};
        default: rd_valid = 1'b0;
      endcase
    end else
`endif
    begin
      case (rd_idx[5:4])
        2'd0:    rd_addr = {2'b00, rd_r};
        2'd1:    rd_addr = 6'd31 - {2'b00, rd_r};
        2'd2:    rd_addr = 6'd32 + {2'b00, rd_r};
        default: rd_valid = 1'b0;
      endcase
    end
  end

`ifndef TDES_KEY_DECRYPT_EN
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  assign subkey = rd_valid ? storage[rd_addr] : 48'h0;

endmodule
`default_nettype wire

// File: tb/tb_tdes_key_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdes_key_sched
// Purpose : Self-checking bench for tdes_key_sched. A behavioural model
//           derives every subkey directly from the FIPS 46-3 definitions
//           (cumulative rotation folded into the PC-1/PC-2 bit indices) and
//           tracks expected busy/sched_done per cycle.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_tdes_key_sched;

  logic         clk      = 1'b0;
  logic         n_rst    = 1'b0;
  logic         key_load = 1'b0;
  logic         decrypt  = 1'b0;
  logic [191:0] keys     = '0;
  logic [5:0]   rd_idx   = '0;
  logic [47:0]  subkey;
  logic         busy;
  logic         sched_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_rd  = 1'b0;

  always #5 clk = ~clk;

  tdes_key_sched dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .key_load   (key_load),
    .keys       (keys),
    .decrypt    (decrypt),
    .rd_idx     (rd_idx),
    .subkey     (subkey),
    .busy       (busy),
    .sched_done (sched_done)
  );

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Subkey of round rnd (1..16): C/D after the cumulative shift is an index
  // rotation of the PC-1 output, so each subkey bit maps straight to a key bit.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int rnd);
    int tot = 0;
    int p, q;
    logic [47:0] sk = '0;
    for (int i = 0; i < rnd; i++) tot += SHIFT_T[i];
    for (int j = 1; j <= 48; j++) begin
      p = PC2_T[j-1];
      if (p <= 28) q = ((p - 1 + tot) % 28) + 1;
      else         q = 28 + ((p - 29 + tot) % 28) + 1;
      sk[48-j] = k[64 - PC1_T[q-1]];
    end
    return sk;
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_gen  = 1'b0;
  bit          m_done = 1'b0;
  bit          m_zero = 1'b1;
  int          m_left = 0;
  logic [63:0] m_k   [3];
  logic [47:0] m_sub [3][17];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_gen = 1'b0; m_done = 1'b0; m_zero = 1'b1; m_left = 0;
    end else if (key_load) begin
      m_k[0] = keys[63:0]; m_k[1] = keys[127:64]; m_k[2] = keys[191:128];
      m_gen = 1'b1; m_done = 1'b0; m_zero = 1'b0; m_left = 48;
    end else if (m_gen) begin
      m_left--;
      if (m_left == 0) begin
        m_gen  = 1'b0;
        m_done = 1'b1;
        for (int s = 0; s < 3; s++)
          for (int r = 1; r <= 16; r++) m_sub[s][r] = ref_subkey(m_k[s], r);
      end
    end
  end

  // Expected read: EDE encrypt = K1 fwd, K2 rev, K3 fwd; DED decrypt = K3 rev, K2 fwd, K1 rev.
  function automatic logic [47:0] exp_read(input logic [5:0] idx);
    int s = int'(idx) / 16;
    int r = int'(idx) % 16;
    if (m_zero || idx >= 6'd48) return 48'h0;
`ifdef TDES_KEY_DECRYPT_EN
    if (decrypt) begin
      case (s)
        0:       return m_sub[2][16-r];
        1:       return m_sub[1][r+1];
        default: return m_sub[0][16-r];
      endcase
    end
`endif
    case (s)
      0:       return m_sub[0][r+1];
      1:       return m_sub[1][16-r];
      default: return m_sub[2][r+1];
    endcase
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("busy", {47'b0, busy}, {47'b0, m_gen});
    chk("sched_done", {47'b0, sched_done}, {47'b0, m_done});
    if (m_done || m_zero) chk("subkey", subkey, exp_read(rd_idx));
  end

  always @(negedge clk) begin
    if (rand_rd) begin
      rd_idx  = 6'($urandom_range(0, 63));
      decrypt = 1'($urandom_range(0, 1));
    end
  end

  task automatic load(input logic [191:0] k);
    @(negedge clk); #1;
    keys = k; key_load = 1'b1;
    @(negedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
      if (sched_done) break;
    end
    chk(name, 48'(cyc), 48'd48);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] idx, input logic dec,
                        input logic [47:0] exp);
    @(negedge clk); #1;
    rd_idx = idx; decrypt = dec;
    #1;
    chk(name, subkey, exp);
  endtask

  task automatic sweep_model(input string name, input int n);
    logic [5:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = 6'(i);
      @(negedge clk); #1;
      rd_idx = idx; decrypt = 1'($urandom_range(0, 1));
      #1;
      chk(name, subkey, exp_read(idx));
    end
  endtask

  function automatic logic [191:0] rand_keys();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] fk;
    fk = {3{64'h133457799BBCDFF1}};

    repeat (3) @(negedge clk);
    #1 n_rst = 1'b1;

    // Reset state: every index reads zero.
    sweep_model("reset_read", 64);

    // FIPS 46-3 reference key in all three slots.
    load(fk);
    wait_done("latency_fips");
    rd_chk("fips_rd0",  6'd0,  1'b0, 48'h1B02EFFC7072);
    rd_chk("fips_rd15", 6'd15, 1'b0, 48'hCB3D8B0E17F5);
    rd_chk("fips_rd16", 6'd16, 1'b0, 48'hCB3D8B0E17F5);
    rd_chk("fips_rd32", 6'd32, 1'b0, 48'h1B02EFFC7072);
    rd_chk("fips_rd50", 6'd50, 1'b0, 48'h0);
`ifdef TDES_KEY_DECRYPT_EN
    rd_chk("fips_dec0",  6'd0,  1'b1, 48'hCB3D8B0E17F5);
    rd_chk("fips_dec16", 6'd16, 1'b1, 48'h1B02EFFC7072);
`else
    rd_chk("fips_dec_ignored", 6'd0, 1'b1, 48'h1B02EFFC7072);
`endif

    // Restart while generating at count 20.
    load(rand_keys());
    repeat (20) @(posedge clk);
    load(rand_keys());
    wait_done("latency_restart");
    sweep_model("restart_read", 64);

    // Reset asserted mid-generation at count 30.
    load(rand_keys());
    repeat (30) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("rst_busy", {47'b0, busy}, 48'h0);
    chk("rst_done", {47'b0, sched_done}, 48'h0);
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 64; i++) rd_chk("rst_read", 6'(i), 1'($urandom_range(0, 1)), 48'h0);

    // Random keys, with occasional restarts and reloads from DONE.
    for (int t = 0; t < 100; t++) begin
      rand_rd = 1'b1;
      load(rand_keys());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 46)) @(posedge clk);
        load(rand_keys());
      end
      wait_done("latency_rand");
      repeat (4) @(posedge clk);
      rand_rd = 1'b0;
      sweep_model("rand_read", 48);
    end

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
